// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions for the host transmitter and the receive path.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        START     = 3'd2,
        SHIFT     = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } ps2_tx_state_t;

    localparam logic [7:0] PS2_CMD_RESET     = 8'hFF;
    localparam logic [7:0] PS2_CMD_EN_REPORT = 8'hF4;
    localparam logic [7:0] PS2_RESP_ACK      = 8'hFA;

    // Data bits plus parity plus stop; the start bit is driven separately.
    localparam int unsigned PS2_FRAME_W = 10;

    // Outbound frame, LSB first: {stop, odd parity, data}.
    function automatic logic [PS2_FRAME_W-1:0] ps2_tx_frame(input logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one PS/2 pad, optional 4-sample stability
// filter and a registered falling-edge strobe.
module ps2_line_sync #(
    parameter bit FILTER_EN = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic line_in,
    output logic line_sync,
    output logic line_fall
);

    logic [1:0] sync_q;

    // Metastability guard; idles high like the bus.
    always_ff @(posedge clk) begin
        if (rst) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], line_in};
    end

    generate
        if (FILTER_EN) begin : g_filter
            logic [3:0] hist_q;
            logic       filt_q;
            logic       fall_q;

            // Level follows only after four equal samples; strobe on the 1->0 change.
            always_ff @(posedge clk) begin
                if (rst) begin
                    hist_q <= 4'hF;
                    filt_q <= 1'b1;
                    fall_q <= 1'b0;
                end else begin
                    hist_q <= {hist_q[2:0], sync_q[1]};
                    fall_q <= 1'b0;
                    if (hist_q == 4'h0 && filt_q) begin
                        filt_q <= 1'b0;
                        fall_q <= 1'b1;
                    end else if (hist_q == 4'hF && !filt_q) begin
                        filt_q <= 1'b1;
                    end
                end
            end

            assign line_sync = filt_q;
            assign line_fall = fall_q;
        end else begin : g_plain
            logic prev_q;
            logic fall_q;

            // Registered falling-edge detect on the synchronized level.
            always_ff @(posedge clk) begin
                if (rst) begin
                    prev_q <= 1'b1;
                    fall_q <= 1'b0;
                end else begin
                    prev_q <= sync_q[1];
                    fall_q <= prev_q & ~sync_q[1];
                end
            end

            assign line_sync = sync_q[1];
            assign line_fall = fall_q;
        end
    endgenerate

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter driving open-drain pads via *_oe.
// Optional build macro: PS2_TX_FILTER_EN adds a glitch filter on PS2Clk.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 65_000_000,
    parameter int unsigned INHIBIT_US  = 100,
    parameter int unsigned TIMEOUT_US  = 15000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int unsigned US_CYC      = CLK_FREQ_HZ / 1_000_000;
    localparam int unsigned INHIBIT_CYC = INHIBIT_US * US_CYC;
    localparam int unsigned TIMEOUT_CYC = TIMEOUT_US * US_CYC;
    localparam int unsigned CNT_W       = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned BIT_W       = 4;

`ifdef PS2_TX_FILTER_EN
    localparam bit CLK_FILTER_EN = 1'b1;
`else
    localparam bit CLK_FILTER_EN = 1'b0;
`endif

    logic clk_sync, clk_fall;
    logic data_sync, data_fall_unused;

    ps2_line_sync #(.FILTER_EN(CLK_FILTER_EN)) u_clk_sync (
        .clk       (clk),
        .rst       (rst),
        .line_in   (ps2_clk_in),
        .line_sync (clk_sync),
        .line_fall (clk_fall)
    );

    ps2_line_sync #(.FILTER_EN(1'b0)) u_data_sync (
        .clk       (clk),
        .rst       (rst),
        .line_in   (ps2_data_in),
        .line_sync (data_sync),
        .line_fall (data_fall_unused)
    );

    ps2_tx_state_t          state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [PS2_FRAME_W-1:0] frame_q, frame_d;
    logic                   clk_oe_d, data_oe_d, done_d, err_d;
    logic                   in_frame;

    // State, counters and all outputs registered together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            frame_q     <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;
            tx_ready    <= 1'b1;
            tx_busy     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            frame_q     <= frame_d;
            ps2_clk_oe  <= clk_oe_d;
            ps2_data_oe <= data_oe_d;
            tx_done     <= done_d;
            tx_err      <= err_d;
            tx_ready    <= (state_d == IDLE);
            tx_busy     <= (state_d != IDLE);
        end
    end

    // Next-state, counters and pad drive; timeout overrides everything after release.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        frame_d   = frame_q;
        clk_oe_d  = ps2_clk_oe;
        data_oe_d = ps2_data_oe;
        done_d    = 1'b0;
        err_d     = 1'b0;
        in_frame  = (state_q == SHIFT) || (state_q == ACK) || (state_q == WAIT_IDLE);

        case (state_q)
            IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                cnt_d     = '0;
                bit_d     = '0;
                if (tx_valid && tx_ready) begin
                    frame_d  = ps2_tx_frame(tx_data);
                    clk_oe_d = 1'b1;
                    state_d  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt_q == CNT_W'(INHIBIT_CYC - 1)) begin
                    cnt_d     = '0;
                    data_oe_d = 1'b1;
                    state_d   = START;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            START: begin
                if (cnt_q == CNT_W'(US_CYC - 1)) begin
                    cnt_d    = '0;
                    clk_oe_d = 1'b0;
                    state_d  = SHIFT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SHIFT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (clk_fall) begin
                    data_oe_d = ~frame_q[bit_q];
                    bit_d     = bit_q + BIT_W'(1);
                    if (bit_q == BIT_W'(PS2_FRAME_W - 1)) state_d = ACK;
                end
            end
            ACK: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (clk_fall) begin
                    if (!data_sync) begin
                        state_d = WAIT_IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (clk_sync && data_sync) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
            end
        endcase

        if (in_frame && cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            state_d   = IDLE;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            done_d    = 1'b0;
            err_d     = 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a behavioural PS/2 device model.
module tb_ps2_host_tx;

    localparam int CLK_HZ = 10_000_000;
    localparam int INH_US = 100;
    localparam int TO_US  = 300;
    localparam int US     = CLK_HZ / 1_000_000;
    localparam int INH    = INH_US * US;
    localparam int TO     = TO_US * US;
    localparam int HP     = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_busy, tx_done, tx_err;
    logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;

    assign ps2_clk_in  = ~ps2_clk_oe & dev_clk;
    assign ps2_data_in = ~ps2_data_oe & dev_data;

    ps2_host_tx #(
        .CLK_FREQ_HZ (CLK_HZ),
        .INHIBIT_US  (INH_US),
        .TIMEOUT_US  (TO_US)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_err      (tx_err),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;

    // Pulse bookkeeping for the whole run.
    always @(negedge clk) begin
        if (tx_done) done_cnt++;
        if (tx_err) err_cnt++;
        if (tx_done && tx_err) both_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Device-side view of a frame: start bit at [0], data LSB first, odd parity, stop.
    function automatic logic [10:0] model_frame(input logic [7:0] d);
        logic par;
        par = (($countones(d) % 2) == 0);
        return {1'b1, par, d, 1'b0};
    endfunction

    task automatic issue(input logic [7:0] d, output bit ok);
        int n;
        n = 0;
        while (!tx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 50);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'h00;
    endtask

    // Drives one complete transfer as the device; returns what the device saw.
    task automatic run_frame(input logic [7:0] d, input bit ack, input bit mid_valid,
                             input bit glitch, output int inh, output int st,
                             output logic [10:0] bits, output int ndone, output int nerr,
                             output logic rdy_n1, output logic rdy_mid,
                             output logic rdy_after, output bit to);
        int  d0, e0;
        bit  ok, seen;
        inh = 0; st = 0; bits = '0; rdy_mid = 1'b0; rdy_after = 1'b0; to = 1'b0;
        seen = 1'b0;
        d0 = done_cnt;
        e0 = err_cnt;
        issue(d, ok);
        if (!ok) to = 1'b1;
        rdy_n1 = tx_ready;
        while (ps2_clk_oe && !ps2_data_oe && inh < INH + 50) begin
            inh++;
            @(negedge clk);
        end
        while (ps2_clk_oe && ps2_data_oe && st < US + 50) begin
            st++;
            @(negedge clk);
        end
        bits[0] = ps2_data_in;
        for (int k = 1; k <= 11; k++) begin
            if (k == 11 && ack) dev_data = 1'b0;
            for (int t = 0; t < HP; t++) begin
                if (glitch && k == 5 && t == 10) dev_clk = 1'b0;
                if (glitch && k == 5 && t == 12) dev_clk = 1'b1;
                if (mid_valid && k == 6 && t == 10) begin
                    tx_valid = 1'b1;
                    tx_data  = ~d;
                    rdy_mid  = tx_ready;
                end
                if (mid_valid && k == 6 && t == 11) begin
                    tx_valid = 1'b0;
                    tx_data  = 8'h00;
                end
                @(negedge clk);
            end
            dev_clk = 1'b0;
            if (k <= 10) begin
                repeat (HP) @(negedge clk);
                bits[k] = ps2_data_in;
                dev_clk = 1'b1;
            end
        end
        for (int t = 0; t < 4 * HP && !seen; t++) begin
            if (t == HP) dev_clk = 1'b1;
            if (t == 2 * HP) dev_data = 1'b1;
            @(negedge clk);
            if (tx_done || tx_err) begin
                seen = 1'b1;
                @(negedge clk);
                rdy_after = tx_ready;
            end
        end
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        if (!seen) to = 1'b1;
        repeat (5) @(negedge clk);
        ndone = done_cnt - d0;
        nerr  = err_cnt - e0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (ps2_clk_oe !== 1'b0) begin n_fail++; $display("FAIL reset_clk_oe: got %b want 0", ps2_clk_oe); end
        n_checks++; if (ps2_data_oe !== 1'b0) begin n_fail++; $display("FAIL reset_data_oe: got %b want 0", ps2_data_oe); end
        n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", tx_ready); end
        n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
        n_checks++; if ({tx_done, tx_err} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses: got %b want 00", {tx_done, tx_err}); end
    endtask

    task automatic test_send_f4();
        int inh, st, nd, ne; logic [10:0] b; logic r1, rm, ra; bit to;
        run_frame(8'hF4, 1'b1, 1'b0, 1'b0, inh, st, b, nd, ne, r1, rm, ra, to);
        n_checks++; if (r1 !== 1'b0) begin n_fail++; $display("FAIL f4_ready_after_accept: got %b want 0", r1); end
        n_checks++; if (inh !== INH) begin n_fail++; $display("FAIL f4_inhibit_len: got %0d want %0d", inh, INH); end
        n_checks++; if (st !== US) begin n_fail++; $display("FAIL f4_start_len: got %0d want %0d", st, US); end
        n_checks++; if (b !== model_frame(8'hF4)) begin n_fail++; $display("FAIL f4_bits: got %b want %b", b, model_frame(8'hF4)); end
        n_checks++; if (nd !== 1 || ne !== 0) begin n_fail++; $display("FAIL f4_pulses: got done=%0d err=%0d want 1/0", nd, ne); end
        n_checks++; if (ra !== 1'b1 || to) begin n_fail++; $display("FAIL f4_ready_next: got %b timeout=%0d want 1/0", ra, to); end
    endtask

    task automatic test_send_ff();
        int inh, st, nd, ne; logic [10:0] b; logic r1, rm, ra; bit to;
        run_frame(8'hFF, 1'b1, 1'b0, 1'b0, inh, st, b, nd, ne, r1, rm, ra, to);
        n_checks++; if (b[9] !== 1'b1) begin n_fail++; $display("FAIL ff_parity: got %b want 1", b[9]); end
        n_checks++; if (b !== model_frame(8'hFF)) begin n_fail++; $display("FAIL ff_bits: got %b want %b", b, model_frame(8'hFF)); end
        n_checks++; if (nd !== 1 || ne !== 0) begin n_fail++; $display("FAIL ff_pulses: got done=%0d err=%0d want 1/0", nd, ne); end
    endtask

    task automatic test_nack();
        int inh, st, nd, ne; logic [10:0] b; logic r1, rm, ra; bit to;
        logic [7:0] d;
        d = 8'($urandom);
        run_frame(d, 1'b0, 1'b0, 1'b0, inh, st, b, nd, ne, r1, rm, ra, to);
        n_checks++; if (b !== model_frame(d)) begin n_fail++; $display("FAIL nack_bits: got %b want %b", b, model_frame(d)); end
        n_checks++; if (nd !== 0 || ne !== 1) begin n_fail++; $display("FAIL nack_pulses: got done=%0d err=%0d want 0/1", nd, ne); end
        n_checks++; if (ra !== 1'b1 || to) begin n_fail++; $display("FAIL nack_ready_next: got %b timeout=%0d want 1/0", ra, to); end
    endtask

    task automatic test_timeout();
        bit ok; int n, c, d0;
        d0 = done_cnt;
        issue(8'hA5, ok);
        n = 0;
        while (ps2_clk_oe && n < INH + US + 100) begin @(negedge clk); n++; end
        c = 0;
        while (!tx_err && c < TO + 100) begin @(negedge clk); c++; end
        n_checks++; if (c !== TO) begin n_fail++; $display("FAIL timeout_cycles: got %0d want %0d", c, TO); end
        n_checks++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin n_fail++; $display("FAIL timeout_oe: got %b want 00", {ps2_clk_oe, ps2_data_oe}); end
        @(negedge clk);
        n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL timeout_ready: got %b want 1", tx_ready); end
        n_checks++; if (done_cnt !== d0) begin n_fail++; $display("FAIL timeout_no_done: got %0d want %0d", done_cnt, d0); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit ok; int n, d0, e0;
        int inh, st, nd, ne; logic [10:0] b; logic r1, rm, ra; bit to;
        issue(8'hF4, ok);
        n = 0;
        while (ps2_clk_oe && n < INH + US + 100) begin @(negedge clk); n++; end
        for (int k = 0; k < 4; k++) begin
            repeat (HP) @(negedge clk);
            dev_clk = 1'b0;
            repeat (HP) @(negedge clk);
            dev_clk = 1'b1;
        end
        repeat (HP) @(negedge clk);
        n_checks++; if (ps2_data_oe !== 1'b1) begin n_fail++; $display("FAIL rstmid_bit3_drive: got %b want 1", ps2_data_oe); end
        d0 = done_cnt; e0 = err_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin n_fail++; $display("FAIL rstmid_oe: got %b want 00", {ps2_clk_oe, ps2_data_oe}); end
        n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b want 1", tx_ready); end
        repeat (10) @(negedge clk);
        n_checks++; if (done_cnt !== d0 || err_cnt !== e0) begin n_fail++; $display("FAIL rstmid_pulses: got done+%0d err+%0d want 0/0", done_cnt - d0, err_cnt - e0); end
        run_frame(8'hF4, 1'b1, 1'b0, 1'b0, inh, st, b, nd, ne, r1, rm, ra, to);
        n_checks++; if (b !== model_frame(8'hF4) || nd !== 1 || ne !== 0) begin n_fail++; $display("FAIL rstmid_resend: got bits=%b done=%0d err=%0d", b, nd, ne); end
    endtask

    task automatic test_valid_during_shift();
        int inh, st, nd, ne; logic [10:0] b; logic r1, rm, ra; bit to;
        logic [7:0] d;
        d = 8'($urandom);
        run_frame(d, 1'b1, 1'b1, 1'b0, inh, st, b, nd, ne, r1, rm, ra, to);
        n_checks++; if (rm !== 1'b0) begin n_fail++; $display("FAIL midvalid_ready: got %b want 0", rm); end
        n_checks++; if (b !== model_frame(d)) begin n_fail++; $display("FAIL midvalid_bits: got %b want %b", b, model_frame(d)); end
        n_checks++; if (nd !== 1 || ne !== 0) begin n_fail++; $display("FAIL midvalid_pulses: got done=%0d err=%0d want 1/0", nd, ne); end
        repeat (20) @(negedge clk);
        n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL midvalid_no_requeue: got busy=%b want 0", tx_busy); end
    endtask

`ifdef PS2_TX_FILTER_EN
    task automatic test_glitch();
        int inh, st, nd, ne; logic [10:0] b; logic r1, rm, ra; bit to;
        logic [7:0] d;
        d = 8'($urandom);
        run_frame(d, 1'b1, 1'b0, 1'b1, inh, st, b, nd, ne, r1, rm, ra, to);
        n_checks++; if (b !== model_frame(d)) begin n_fail++; $display("FAIL glitch_bits: got %b want %b", b, model_frame(d)); end
        n_checks++; if (nd !== 1 || ne !== 0) begin n_fail++; $display("FAIL glitch_pulses: got done=%0d err=%0d want 1/0", nd, ne); end
    endtask
`endif

    task automatic test_random();
        int inh, st, nd, ne; logic [10:0] b; logic r1, rm, ra; bit to;
        logic [7:0] d; bit ack;
        for (int i = 0; i < 4; i++) begin
            d   = 8'($urandom);
            ack = 1'($urandom_range(0, 1));
            run_frame(d, ack, 1'b0, 1'b0, inh, st, b, nd, ne, r1, rm, ra, to);
            n_checks++; if (b !== model_frame(d)) begin n_fail++; $display("FAIL rand%0d_bits: got %b want %b", i, b, model_frame(d)); end
            n_checks++; if (nd !== int'(ack) || ne !== int'(!ack)) begin n_fail++; $display("FAIL rand%0d_pulses: got done=%0d err=%0d ack=%0d", i, nd, ne, ack); end
        end
    endtask

    task automatic test_exclusive();
        n_checks++; if (both_cnt !== 0) begin n_fail++; $display("FAIL done_err_overlap: got %0d want 0", both_cnt); end
    endtask

    initial begin
        test_reset();
        test_send_f4();
        test_send_ff();
        test_nack();
        test_timeout();
        test_reset_mid();
        test_valid_during_shift();
`ifdef PS2_TX_FILTER_EN
        test_glitch();
`endif
        test_random();
        test_exclusive();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
